accel_ctrl_bridge: RTL and testbench
====================================

ACCEL_CTRL_BRIDGE -- requirements
Module: accel_ctrl_bridge

Interface
REQ-001 SHALL have parameter NUM_MEM, default 2, number of memory windows (1..4).
REQ-002 SHALL have parameter MEM_WSIZE, default 1024, words per window (power of two).
REQ-003 SHALL have parameter MEM_BASE, default 32'h8000_0000, base address of window 0.
REQ-004 SHALL have parameter MEM_STRIDE, default 32'h1000_0000, address distance between windows.
REQ-005 SHALL have ports clk_i (in, 1, sole clock) and rst_i (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-006 SHALL have bus_req_i, bus_we_i (in, 1), bus_addr_bi, bus_wdata_bi (in, 32), bus_be_bi (in, 4): UDM bus request.
REQ-007 SHALL have bus_ack_o, bus_resp_o (out, 1), bus_rdata_bo (out, 32): accept, read response, read data.
REQ-008 SHALL have mem_we_o (out, NUM_MEM), mem_be_bo (out, 4), mem_addr_bo (out, log2(MEM_WSIZE)), mem_wdata_bo (out, 32), mem_rdata_bi (in, NUM_MEM*32): window RAM ports, read latency 1.
REQ-009 SHALL have ap_start_o (out, 1), ap_done_i, ap_idle_i, ap_ready_i (in, 1), ap_return_bi (in, 32), arg0_bo (out, 32): HLS ap_ctrl_hs accelerator control.

Function
REQ-010 SHALL assert bus_ack_o = bus_req_i & !rd_pending; at most one read outstanding.
REQ-011 SHALL return CSR and unmapped reads with bus_resp_o exactly 1 cycle after accept; window reads exactly 2 cycles after accept.
REQ-012 SHALL decode window k for MEM_BASE+k*MEM_STRIDE <= addr < that+MEM_WSIZE*4; word address = addr[..:2].
REQ-013 SHALL drive mem_we_o[k] for one cycle on accepted window write, passing bus_be_bi to mem_be_bo.
REQ-014 SHALL hold bus_rdata_bo at 0 whenever bus_resp_o is 0.
REQ-015 SHALL implement CSRs: 0x00 CTRL (W: bit0 start, bit1 clear done/err), 0x04 STATUS (R: bit0 busy, bit1 done sticky, bit2 ap_idle_i, bit3 err), 0x08 ARG0 (RW, byte-enable honoured), 0x0C RETVAL (RO), 0x10 CYCLES (RO), 0x14 ID (RO = {NUM_MEM[7:0], 24'h000100}).
REQ-016 SHALL answer unmapped reads with 0, set err; unmapped writes ignored, set err.
REQ-017 SHALL run FSM IDLE -> START on CTRL.bit0 write; START holds ap_start_o=1 until ap_ready_i; START -> RUN on ap_ready_i; RUN -> IDLE on ap_done_i.
REQ-018 SHALL go START -> IDLE directly when ap_ready_i and ap_done_i coincide.
REQ-019 SHALL ignore start writes while busy (state != IDLE) and set err.
REQ-020 SHALL latch ap_return_bi into RETVAL and set done on the ap_done_i cycle.
REQ-021 SHALL clear CYCLES on entry to START, increment each cycle in START/RUN, saturate at 32'hFFFF_FFFF, freeze in IDLE.
REQ-022 SHALL give clear (bit1) priority below a same-cycle done set: done ends set.
REQ-023 SHALL drive arg0_bo from ARG0 continuously.

Reset
REQ-024 SHALL on rst_i clear all outputs, FSM to IDLE, rd_pending, ARG0, RETVAL, CYCLES, done, err to 0.
REQ-025 SHALL drop ap_start_o and any pending response on reset mid-operation; no response issued after reset.

Structure
REQ-026 SHALL place CSR offsets, STATUS bit indices, ID version constant and FSM state enum in package accel_bridge_pkg.
REQ-027 SHALL implement FSM plus cycle counter in sub-module accel_ap_ctrl; decode/response path in the top.

Verification
REQ-028 Write 0x8000_0010=0x1234_5678, read back -> resp 2 cycles after ack, rdata 0x1234_5678, mem_we_o=2'b01.
REQ-029 Write ARG0=0xA5, CTRL=1; model ap_ready after 3 cycles, ap_done with ap_return 0x55 after 10 -> ap_start_o high 4 cycles, RETVAL=0x55, STATUS=0x6 (done|idle), CYCLES=11.
REQ-030 CTRL=1 while RUN -> err set, STATUS bit3=1, no second ap_start_o; CTRL=2 -> done and err cleared.
REQ-031 Read 0x0000_0040 -> resp after 1 cycle, rdata 0, err set.
REQ-032 Back-to-back reads window 1 then STATUS -> second ack withheld until first resp; responses in order.
REQ-033 rst_i pulse during RUN -> ap_start_o 0, STATUS 0 except idle bit, CYCLES 0.

Source files
------------

// File: rtl/accel_bridge_pkg.sv
// Shared constants for the accelerator control bridge:
// CSR map, STATUS layout, ID version and ap_ctrl_hs FSM states.
package accel_bridge_pkg;

    localparam logic [7:0] CSR_CTRL   = 8'h00;
    localparam logic [7:0] CSR_STATUS = 8'h04;
    localparam logic [7:0] CSR_ARG0   = 8'h08;
    localparam logic [7:0] CSR_RETVAL = 8'h0C;
    localparam logic [7:0] CSR_CYCLES = 8'h10;
    localparam logic [7:0] CSR_ID     = 8'h14;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_IDLE = 2;
    localparam int STAT_ERR  = 3;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam logic [23:0] ID_VERSION = 24'h000100;
    localparam logic [31:0] CYC_MAX    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        AP_IDLE,
        AP_START,
        AP_RUN
    } ap_state_t;

    function automatic logic [31:0] status_word(
        input logic busy,
        input logic done,
        input logic idle,
        input logic err
    );
        logic [31:0] w;
        w            = '0;
        w[STAT_BUSY] = busy;
        w[STAT_DONE] = done;
        w[STAT_IDLE] = idle;
        w[STAT_ERR]  = err;
        return w;
    endfunction

endpackage

// File: rtl/accel_ctrl_bridge_ap_ctrl.sv
// ap_ctrl_hs handshake sequencer with a saturating run-cycle counter.
// START holds ap_start until ap_ready; RUN waits for ap_done.
module accel_ap_ctrl
    import accel_bridge_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_ap_ready,
    input  logic        i_ap_done,
    output logic        o_ap_start,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_cycles
);

    ap_state_t   r_state;
    ap_state_t   w_next;
    logic [31:0] r_cycles;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= AP_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        o_ap_start = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            AP_IDLE: begin
                if (i_start) begin
                    w_next = AP_START;
                end
            end
            AP_START: begin
                o_ap_start = 1'b1;
                if (i_ap_ready) begin
                    // ready and done together: the call finished in one beat
                    if (i_ap_done) begin
                        w_next = AP_IDLE;
                        o_done = 1'b1;
                    end else begin
                        w_next = AP_RUN;
                    end
                end
            end
            AP_RUN: begin
                if (i_ap_done) begin
                    w_next = AP_IDLE;
                    o_done = 1'b1;
                end
            end
            default: begin
                w_next = AP_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cycles <= '0;
        end else if (r_state == AP_IDLE && w_next == AP_START) begin
            r_cycles <= '0;
        end else if (r_state != AP_IDLE && r_cycles != CYC_MAX) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign o_busy   = (r_state != AP_IDLE);
    assign o_cycles = r_cycles;

endmodule

// File: rtl/accel_ctrl_bridge.sv
// Bus-to-accelerator bridge: decodes CSRs and RAM windows, returns
// read data in order with one read outstanding, drives ap_ctrl_hs.
module accel_ctrl_bridge
    import accel_bridge_pkg::*;
#(
    parameter int          NUM_MEM    = 2,
    parameter int          MEM_WSIZE  = 1024,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_STRIDE = 32'h1000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         bus_req_i,
    input  logic                         bus_we_i,
    input  logic [31:0]                  bus_addr_bi,
    input  logic [31:0]                  bus_wdata_bi,
    input  logic [3:0]                   bus_be_bi,
    output logic                         bus_ack_o,
    output logic                         bus_resp_o,
    output logic [31:0]                  bus_rdata_bo,
    output logic [NUM_MEM-1:0]           mem_we_o,
    output logic [3:0]                   mem_be_bo,
    output logic [$clog2(MEM_WSIZE)-1:0] mem_addr_bo,
    output logic [31:0]                  mem_wdata_bo,
    input  logic [NUM_MEM*32-1:0]        mem_rdata_bi,
    output logic                         ap_start_o,
    input  logic                         ap_done_i,
    input  logic                         ap_idle_i,
    input  logic                         ap_ready_i,
    input  logic [31:0]                  ap_return_bi,
    output logic [31:0]                  arg0_bo
);

    localparam int          MEM_AW    = $clog2(MEM_WSIZE);
    localparam logic [31:0] WIN_BYTES = 32'(MEM_WSIZE * 4);

    logic              w_acc;
    logic              w_rd;
    logic              w_wr;
    logic              w_win_hit;
    logic [1:0]        w_win_idx;
    logic [MEM_AW-1:0] w_waddr;
    logic [31:0]       w_off;
    logic              w_csr_hit;
    logic [31:0]       w_csr_rdata;
    logic [31:0]       w_mem_rd;
    logic              w_unmapped;
    logic              w_ctrl_wr;
    logic              w_start_req;
    logic              w_clear;
    logic              w_busy;
    logic              w_done;
    logic [31:0]       w_cycles;

    logic              r_win_pend;
    logic [1:0]        r_win_idx;
    logic              r_resp;
    logic [31:0]       r_rdata;
    logic [31:0]       r_arg0;
    logic [31:0]       r_retval;
    logic              r_done;
    logic              r_err;

    // only a window read is still in flight after its accept cycle
    assign bus_ack_o = bus_req_i & ~r_win_pend & ~rst_i;
    assign w_acc     = bus_ack_o;
    assign w_rd      = w_acc & ~bus_we_i;
    assign w_wr      = w_acc & bus_we_i;

    always_comb begin
        w_win_hit = 1'b0;
        w_win_idx = '0;
        w_waddr   = '0;
        w_off     = '0;
        for (int k = 0; k < NUM_MEM; k++) begin
            w_off = bus_addr_bi - (MEM_BASE + 32'(k) * MEM_STRIDE);
            if (!w_win_hit && w_off < WIN_BYTES) begin
                w_win_hit = 1'b1;
                w_win_idx = 2'(k);
                w_waddr   = w_off[MEM_AW+1:2];
            end
        end
    end

    always_comb begin
        w_csr_hit   = 1'b0;
        w_csr_rdata = '0;
        if (bus_addr_bi[31:8] == 24'd0) begin
            case (bus_addr_bi[7:0])
                CSR_CTRL: begin
                    w_csr_hit = 1'b1;
                end
                CSR_STATUS: begin
                    w_csr_hit   = 1'b1;
                    w_csr_rdata = status_word(w_busy, r_done, ap_idle_i, r_err);
                end
                CSR_ARG0: begin
                    w_csr_hit   = 1'b1;
                    w_csr_rdata = r_arg0;
                end
                CSR_RETVAL: begin
                    w_csr_hit   = 1'b1;
                    w_csr_rdata = r_retval;
                end
                CSR_CYCLES: begin
                    w_csr_hit   = 1'b1;
                    w_csr_rdata = w_cycles;
                end
                CSR_ID: begin
                    w_csr_hit   = 1'b1;
                    w_csr_rdata = {8'(NUM_MEM), ID_VERSION};
                end
                default: begin
                    w_csr_hit = 1'b0;
                end
            endcase
        end
    end

    assign w_unmapped  = ~w_win_hit & ~w_csr_hit;
    assign w_ctrl_wr   = w_wr & w_csr_hit & (bus_addr_bi[7:0] == CSR_CTRL)
                       & bus_be_bi[0];
    assign w_start_req = w_ctrl_wr & bus_wdata_bi[CTRL_START];
    assign w_clear     = w_ctrl_wr & bus_wdata_bi[CTRL_CLEAR];

    always_comb begin
        mem_we_o = '0;
        for (int k = 0; k < NUM_MEM; k++) begin
            if (w_wr && w_win_hit && w_win_idx == 2'(k)) begin
                mem_we_o[k] = 1'b1;
            end
        end
    end

    assign mem_be_bo    = w_acc ? bus_be_bi : 4'd0;
    assign mem_addr_bo  = (w_acc & w_win_hit) ? w_waddr : '0;
    assign mem_wdata_bo = (w_wr & w_win_hit) ? bus_wdata_bi : 32'd0;

    always_comb begin
        w_mem_rd = '0;
        for (int k = 0; k < NUM_MEM; k++) begin
            if (r_win_idx == 2'(k)) begin
                w_mem_rd = mem_rdata_bi[k*32 +: 32];
            end
        end
    end

    // CSR data is captured at accept; window data one cycle later
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_win_pend <= 1'b0;
            r_win_idx  <= '0;
            r_resp     <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_resp  <= 1'b0;
            r_rdata <= '0;
            if (r_win_pend) begin
                r_win_pend <= 1'b0;
                r_resp     <= 1'b1;
                r_rdata    <= w_mem_rd;
            end
            if (w_rd) begin
                if (w_win_hit) begin
                    r_win_pend <= 1'b1;
                    r_win_idx  <= w_win_idx;
                end else begin
                    r_resp  <= 1'b1;
                    r_rdata <= w_csr_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_arg0   <= '0;
            r_retval <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_wr && w_csr_hit && bus_addr_bi[7:0] == CSR_ARG0) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus_be_bi[b]) begin
                        r_arg0[b*8 +: 8] <= bus_wdata_bi[b*8 +: 8];
                    end
                end
            end
            if (w_done) begin
                r_retval <= ap_return_bi;
            end
            if (w_clear) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_done) begin
                r_done <= 1'b1;
            end
            if ((w_acc & w_unmapped) | (w_start_req & w_busy)) begin
                r_err <= 1'b1;
            end
        end
    end

    accel_ap_ctrl u_ap_ctrl (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_start    (w_start_req),
        .i_ap_ready (ap_ready_i),
        .i_ap_done  (ap_done_i),
        .o_ap_start (ap_start_o),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_cycles   (w_cycles)
    );

    assign bus_resp_o   = r_resp;
    assign bus_rdata_bo = r_rdata;
    assign arg0_bo      = r_arg0;

endmodule

// File: tb/tb_accel_ctrl_bridge.sv
// Directed bench for accel_ctrl_bridge: bus vector table plus
// hand-written accelerator handshake and reset sequences.
module tb_accel_ctrl_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        bus_req_i;
    logic        bus_we_i;
    logic [31:0] bus_addr_bi;
    logic [31:0] bus_wdata_bi;
    logic [3:0]  bus_be_bi;
    logic        bus_ack_o;
    logic        bus_resp_o;
    logic [31:0] bus_rdata_bo;
    logic [1:0]  mem_we_o;
    logic [3:0]  mem_be_bo;
    logic [9:0]  mem_addr_bo;
    logic [31:0] mem_wdata_bo;
    logic [63:0] mem_rdata_bi;
    logic        ap_start_o;
    logic        ap_done_i;
    logic        ap_idle_i;
    logic        ap_ready_i;
    logic [31:0] ap_return_bi;
    logic [31:0] arg0_bo;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ram0 [1024];
    logic [31:0] ram1 [1024];
    logic [31:0] q0;
    logic [31:0] q1;

    accel_ctrl_bridge dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus_req_i    (bus_req_i),
        .bus_we_i     (bus_we_i),
        .bus_addr_bi  (bus_addr_bi),
        .bus_wdata_bi (bus_wdata_bi),
        .bus_be_bi    (bus_be_bi),
        .bus_ack_o    (bus_ack_o),
        .bus_resp_o   (bus_resp_o),
        .bus_rdata_bo (bus_rdata_bo),
        .mem_we_o     (mem_we_o),
        .mem_be_bo    (mem_be_bo),
        .mem_addr_bo  (mem_addr_bo),
        .mem_wdata_bo (mem_wdata_bo),
        .mem_rdata_bi (mem_rdata_bi),
        .ap_start_o   (ap_start_o),
        .ap_done_i    (ap_done_i),
        .ap_idle_i    (ap_idle_i),
        .ap_ready_i   (ap_ready_i),
        .ap_return_bi (ap_return_bi),
        .arg0_bo      (arg0_bo)
    );

    always #5 clk_i = ~clk_i;

    // window RAMs with one-cycle read latency
    always @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we_o[0] && mem_be_bo[b])
                ram0[mem_addr_bo][b*8 +: 8] <= mem_wdata_bo[b*8 +: 8];
            if (mem_we_o[1] && mem_be_bo[b])
                ram1[mem_addr_bo][b*8 +: 8] <= mem_wdata_bo[b*8 +: 8];
        end
        q0 <= ram0[mem_addr_bo];
        q1 <= ram1[mem_addr_bo];
    end
    assign mem_rdata_bi = {q1, q0};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // starts and ends 1 time unit after a rising edge
    task automatic xfer(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output int lat,
                        output logic [1:0] we_seen);
        int n;
        n            = 0;
        rd           = '0;
        lat          = 0;
        we_seen      = '0;
        bus_req_i    = 1'b1;
        bus_we_i     = we;
        bus_addr_bi  = addr;
        bus_wdata_bi = wd;
        bus_be_bi    = be;
        @(negedge clk_i);
        while (!bus_ack_o && n < 20) begin
            n++;
            cyc();
            @(negedge clk_i);
        end
        if (!bus_ack_o) chk("ack_timeout", 32'(bus_ack_o), 32'd1);
        we_seen = mem_we_o;
        cyc();
        bus_req_i    = 1'b0;
        bus_we_i     = 1'b0;
        bus_addr_bi  = '0;
        bus_wdata_bi = '0;
        bus_be_bi    = '0;
        if (!we) begin
            lat = 1;
            @(negedge clk_i);
            while (!bus_resp_o && lat < 8) begin
                lat++;
                cyc();
                @(negedge clk_i);
            end
            if (!bus_resp_o) chk("resp_timeout", 32'(bus_resp_o), 32'd1);
            rd = bus_rdata_bo;
            cyc();
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        int          lat;
        logic [1:0]  ws;
        xfer(1'b1, addr, wd, 4'hF, rd, lat, ws);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr,
                          input logic [31:0] exp);
        logic [31:0] rd;
        int          lat;
        logic [1:0]  ws;
        xfer(1'b0, addr, '0, 4'hF, rd, lat, ws);
        chk(name, rd, exp);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic [1:0]  exp_we;
    } vec_t;

    function automatic vec_t mkv(input string nm, input logic we,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] be, input logic [31:0] er,
                                 input int el, input logic [1:0] ew);
        vec_t v;
        v.name    = nm;
        v.we      = we;
        v.addr    = a;
        v.wd      = d;
        v.be      = be;
        v.exp_rd  = er;
        v.exp_lat = el;
        v.exp_we  = ew;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        logic [31:0] rd;
        int          lat;
        logic [1:0]  ws;
        int          starts;
        int          resps;

        vt.push_back(mkv("w0_wr",     1, 32'h8000_0010, 32'h1234_5678, 4'hF, 0, 0, 2'b01));
        vt.push_back(mkv("w0_rd",     0, 32'h8000_0010, 0, 4'hF, 32'h1234_5678, 2, 2'b00));
        vt.push_back(mkv("w1_wr",     1, 32'h9000_0000, 32'hCAFE_BABE, 4'hF, 0, 0, 2'b10));
        vt.push_back(mkv("w1_rd",     0, 32'h9000_0000, 0, 4'hF, 32'hCAFE_BABE, 2, 2'b00));
        vt.push_back(mkv("w0_clr",    1, 32'h8000_0014, 32'h0, 4'hF, 0, 0, 2'b01));
        vt.push_back(mkv("w0_be_wr",  1, 32'h8000_0014, 32'hFFFF_FFFF, 4'b0101, 0, 0, 2'b01));
        vt.push_back(mkv("w0_be_rd",  0, 32'h8000_0014, 0, 4'hF, 32'h00FF_00FF, 2, 2'b00));
        vt.push_back(mkv("w0_top_wr", 1, 32'h8000_0FFC, 32'hDEAD_0001, 4'hF, 0, 0, 2'b01));
        vt.push_back(mkv("w0_top_rd", 0, 32'h8000_0FFC, 0, 4'hF, 32'hDEAD_0001, 2, 2'b00));
        vt.push_back(mkv("past_w0_wr",1, 32'h8000_1000, 32'h5555_5555, 4'hF, 0, 0, 2'b00));
        vt.push_back(mkv("arg0_wr",   1, 32'h0000_0008, 32'h1122_3344, 4'hF, 0, 0, 2'b00));
        vt.push_back(mkv("arg0_rd",   0, 32'h0000_0008, 0, 4'hF, 32'h1122_3344, 1, 2'b00));
        vt.push_back(mkv("arg0_be_wr",1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0010, 0, 0, 2'b00));
        vt.push_back(mkv("arg0_be_rd",0, 32'h0000_0008, 0, 4'hF, 32'h1122_CC44, 1, 2'b00));
        vt.push_back(mkv("id_rd",     0, 32'h0000_0014, 0, 4'hF, 32'h0200_0100, 1, 2'b00));
        vt.push_back(mkv("unmap_rd",  0, 32'h0000_0040, 0, 4'hF, 32'h0, 1, 2'b00));
        vt.push_back(mkv("past_w0_rd",0, 32'h8000_1000, 0, 4'hF, 32'h0, 1, 2'b00));
        vt.push_back(mkv("status_err",0, 32'h0000_0004, 0, 4'hF, 32'h0000_000C, 1, 2'b00));

        rst_i        = 1'b1;
        bus_req_i    = 1'b0;
        bus_we_i     = 1'b0;
        bus_addr_bi  = '0;
        bus_wdata_bi = '0;
        bus_be_bi    = '0;
        ap_done_i    = 1'b0;
        ap_ready_i   = 1'b0;
        ap_idle_i    = 1'b1;
        ap_return_bi = '0;
        repeat (3) cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ack",    32'(bus_ack_o),  32'd0);
        chk("rst_resp",   32'(bus_resp_o), 32'd0);
        chk("rst_rdata",  bus_rdata_bo,    32'd0);
        chk("rst_start",  32'(ap_start_o), 32'd0);
        chk("rst_arg0",   arg0_bo,         32'd0);
        chk("rst_mem_we", 32'(mem_we_o),   32'd0);
        cyc();
        rd_chk("rst_status", 32'h04, 32'h0000_0004);
        rd_chk("rst_cycles", 32'h10, 32'h0);
        rd_chk("rst_retval", 32'h0C, 32'h0);

        foreach (vt[i]) begin
            xfer(vt[i].we, vt[i].addr, vt[i].wd, vt[i].be, rd, lat, ws);
            chk({vt[i].name, "_mem_we"}, 32'(ws), 32'(vt[i].exp_we));
            if (!vt[i].we) begin
                chk({vt[i].name, "_data"}, rd, vt[i].exp_rd);
                chk({vt[i].name, "_lat"}, 32'(lat), 32'(vt[i].exp_lat));
            end
        end

        wr(32'h00, 32'h2);
        rd_chk("clr_status", 32'h04, 32'h0000_0004);

        // normal call: ready on 4th start cycle, done 11 cycles in
        wr(32'h08, 32'h0000_00A5);
        @(negedge clk_i);
        chk("arg0_port", arg0_bo, 32'h0000_00A5);
        cyc();
        wr(32'h00, 32'h1);
        starts = 0;
        for (int i = 1; i <= 14; i++) begin
            ap_ready_i   = (i == 4);
            ap_done_i    = (i == 11);
            ap_return_bi = (i == 11) ? 32'h55 : 32'h0;
            ap_idle_i    = (i >= 12);
            @(negedge clk_i);
            if (ap_start_o) starts++;
            cyc();
        end
        ap_ready_i   = 1'b0;
        ap_done_i    = 1'b0;
        ap_return_bi = '0;
        chk("start_cycles", 32'(starts), 32'd4);
        rd_chk("run_retval", 32'h0C, 32'h55);
        rd_chk("run_status", 32'h04, 32'h6);
        rd_chk("run_cycles", 32'h10, 32'd11);

        // start while busy
        wr(32'h00, 32'h1);
        ap_idle_i  = 1'b0;
        ap_ready_i = 1'b1;
        cyc();
        ap_ready_i = 1'b0;
        wr(32'h00, 32'h1);
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (ap_start_o) starts++;
            cyc();
        end
        chk("busy_no_restart", 32'(starts), 32'd0);
        rd_chk("busy_status", 32'h04, 32'hB);
        ap_done_i    = 1'b1;
        ap_return_bi = 32'h77;
        cyc();
        ap_done_i    = 1'b0;
        ap_idle_i    = 1'b1;
        rd_chk("busy_done_status", 32'h04, 32'hE);
        wr(32'h00, 32'h2);
        rd_chk("busy_clr_status", 32'h04, 32'h4);

        // done and clear in the same cycle: done must survive
        wr(32'h00, 32'h1);
        ap_idle_i  = 1'b0;
        ap_ready_i = 1'b1;
        cyc();
        ap_ready_i   = 1'b0;
        ap_done_i    = 1'b1;
        ap_return_bi = 32'h99;
        ap_idle_i    = 1'b1;
        wr(32'h00, 32'h2);
        ap_done_i    = 1'b0;
        rd_chk("done_vs_clr", 32'h04, 32'h6);
        rd_chk("done_vs_clr_ret", 32'h0C, 32'h99);

        // ready and done coincide in START
        wr(32'h00, 32'h2);
        wr(32'h00, 32'h1);
        ap_idle_i    = 1'b0;
        ap_ready_i   = 1'b1;
        ap_done_i    = 1'b1;
        ap_return_bi = 32'h33;
        @(negedge clk_i);
        chk("coin_start_hi", 32'(ap_start_o), 32'd1);
        cyc();
        ap_ready_i = 1'b0;
        ap_done_i  = 1'b0;
        ap_idle_i  = 1'b1;
        @(negedge clk_i);
        chk("coin_start_lo", 32'(ap_start_o), 32'd0);
        cyc();
        rd_chk("coin_status", 32'h04, 32'h6);
        rd_chk("coin_cycles", 32'h10, 32'd1);
        rd_chk("coin_retval", 32'h0C, 32'h33);

        // window read then STATUS back to back
        bus_req_i   = 1'b1;
        bus_we_i    = 1'b0;
        bus_be_bi   = 4'hF;
        bus_addr_bi = 32'h9000_0000;
        @(negedge clk_i);
        chk("b2b_ack1", 32'(bus_ack_o), 32'd1);
        cyc();
        bus_addr_bi = 32'h0000_0004;
        @(negedge clk_i);
        chk("b2b_ack_held", 32'(bus_ack_o), 32'd0);
        chk("b2b_no_resp",  32'(bus_resp_o), 32'd0);
        cyc();
        @(negedge clk_i);
        chk("b2b_resp1",  32'(bus_resp_o), 32'd1);
        chk("b2b_data1",  bus_rdata_bo, 32'hCAFE_BABE);
        chk("b2b_ack2",   32'(bus_ack_o), 32'd1);
        cyc();
        bus_req_i   = 1'b0;
        bus_addr_bi = '0;
        @(negedge clk_i);
        chk("b2b_resp2", 32'(bus_resp_o), 32'd1);
        chk("b2b_data2", bus_rdata_bo, 32'h6);
        cyc();
        @(negedge clk_i);
        chk("b2b_idle_rdata", bus_rdata_bo, 32'h0);
        cyc();

        // reset while running with a window read in flight
        wr(32'h08, 32'h5A);
        wr(32'h00, 32'h1);
        ap_idle_i  = 1'b0;
        ap_ready_i = 1'b1;
        cyc();
        ap_ready_i = 1'b0;
        repeat (3) cyc();
        bus_req_i   = 1'b1;
        bus_we_i    = 1'b0;
        bus_addr_bi = 32'h8000_0010;
        @(negedge clk_i);
        chk("rr_ack", 32'(bus_ack_o), 32'd1);
        cyc();
        bus_req_i   = 1'b0;
        bus_addr_bi = '0;
        rst_i       = 1'b1;
        ap_idle_i   = 1'b1;
        cyc();
        rst_i = 1'b0;
        resps  = 0;
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (bus_resp_o) resps++;
            if (ap_start_o) starts++;
            cyc();
        end
        chk("rr_no_resp",  32'(resps),  32'd0);
        chk("rr_no_start", 32'(starts), 32'd0);
        chk("rr_arg0",     arg0_bo,     32'd0);
        rd_chk("rr_status", 32'h04, 32'h4);
        rd_chk("rr_cycles", 32'h10, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
